// File: rtl/mem_copy_engine_if.sv
// Control and memory bus bundle for the memory copy engine.
// master drives requests and read data, slave is the engine.
interface mem_copy_engine_if;
  logic        start;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic        error;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport master (
    output start, src_base, dst_base, len, mem_dout,
    input  busy, done, error,
    input  mem_ren, mem_wen, mem_addr, mem_din
  );

  modport slave (
    input  start, src_base, dst_base, len, mem_dout,
    output busy, done, error,
    output mem_ren, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one read cycle then one write
// cycle per word, ascending addresses, all outputs registered.
module mem_copy_engine #(
  parameter int MEM_WORDS = 1024
) (
  input logic i_clock,
  input logic i_reset,
  mem_copy_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [10:0] r_len;
  logic [10:0] r_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_ren;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  logic [32:0] w_src_end;
  logic [32:0] w_dst_end;
  logic        w_illegal;
  logic [10:0] w_idx_nxt;
  logic        w_more;

  // Bounds check at 33 bits so base+len can never wrap.
  assign w_src_end = {1'b0, bus.src_base} + {22'b0, bus.len};
  assign w_dst_end = {1'b0, bus.dst_base} + {22'b0, bus.len};
  assign w_illegal = (w_src_end > 33'(MEM_WORDS)) ||
                     (w_dst_end > 33'(MEM_WORDS));
  assign w_idx_nxt = r_idx + 11'd1;
  assign w_more    = w_idx_nxt < r_len;

  // Sequencer; outputs are computed for the state being entered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_src <= bus.src_base;
            r_dst <= bus.dst_base;
            r_len <= bus.len;
            r_idx <= '0;
            if (w_illegal) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else if (bus.len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_ren   <= 1'b1;
              r_busy  <= 1'b1;
              r_addr  <= bus.src_base;
            end
          end
        end
        S_READ: begin
          r_state <= S_WRITE;
          r_wen   <= 1'b1;
          r_busy  <= 1'b1;
          r_addr  <= r_dst + {21'b0, r_idx};
          r_data  <= bus.mem_dout;
        end
        S_WRITE: begin
          r_idx <= w_idx_nxt;
          if (w_more) begin
            r_state <= S_READ;
            r_ren   <= 1'b1;
            r_busy  <= 1'b1;
            r_addr  <= r_src + {21'b0, w_idx_nxt};
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.error    = r_error;
  assign bus.mem_ren  = r_ren;
  assign bus.mem_wen  = r_wen;
  assign bus.mem_addr = r_addr;
  assign bus.mem_din  = r_data;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: memory model plus a sequential
// reference copy that predicts every cycle and the final memory.
module tb_mem_copy_engine;
  localparam int MW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_copy_engine_if bus ();

  mem_copy_engine #(.MEM_WORDS(MW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];
  int n_cmp = 0;
  int n_bad = 0;

  assign bus.mem_dout = (bus.mem_ren && bus.mem_addr < MW) ?
                        mem[bus.mem_addr[9:0]] : 32'h0;

  // Memory writes commit at the negedge inside the write cycle.
  always @(negedge clk)
    if (bus.mem_wen && bus.mem_addr < MW)
      mem[bus.mem_addr[9:0]] = bus.mem_din;

  // Read and write enables must never overlap.
  always @(negedge clk) begin
    n_cmp++;
    if (bus.mem_ren && bus.mem_wen) begin
      n_bad++;
      $display("FAIL ren_wen_excl t=%0t ren=%b wen=%b want not both",
               $time, bus.mem_ren, bus.mem_wen);
    end
  end

  // obs layout: busy,done,error,ren,wen,addr[31:0],din[31:0]
  function automatic logic [68:0] obs();
    return {bus.busy, bus.done, bus.error, bus.mem_ren,
            bus.mem_wen, bus.mem_addr, bus.mem_din};
  endfunction

  task automatic init_mem();
    logic [31:0] v;
    for (int i = 0; i < MW; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < MW; i++)
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s mem: %0d words differ, first @%0d got %h want %h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Issue one request and check every cycle through the idle cycle
  // that follows completion. Ends #1 into that idle cycle.
  task automatic run_copy(input string name, input logic [31:0] src,
                          input logic [31:0] dst, input int len,
                          input bit noise);
    logic [68:0] exp_o;
    logic [31:0] d;
    bit illegal;
    int total;
    int k;
    illegal = (longint'(src) + len > MW) || (longint'(dst) + len > MW);
    bus.src_base = src;
    bus.dst_base = dst;
    bus.len = 11'(len);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total = illegal ? 1 : 2 * len + 1;
    for (int c = 1; c <= total; c++) begin
      if (noise && c < total) begin
        bus.start = 1'($urandom);
        bus.src_base = $urandom;
        bus.dst_base = $urandom_range(0, MW - 1);
        bus.len = 11'($urandom_range(0, 1024));
      end else begin
        bus.start = 1'b0;
      end
      exp_o = '0;
      if (illegal) begin
        exp_o[66] = 1'b1;
      end else if (c == total) begin
        exp_o[67] = 1'b1;
      end else begin
        k = (c - 1) / 2;
        exp_o[68] = 1'b1;
        if (c % 2 == 1) begin
          exp_o[65] = 1'b1;
          exp_o[63:32] = src + 32'(k);
        end else begin
          d = ref_mem[int'(src) + k];
          ref_mem[int'(dst) + k] = d;
          exp_o[64] = 1'b1;
          exp_o[63:32] = dst + 32'(k);
          exp_o[31:0] = d;
        end
      end
      n_cmp++;
      if (obs() !== exp_o) begin
        n_bad++;
        $display("FAIL %s cycle %0d got %h want %h", name, c, obs(), exp_o);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    n_cmp++;
    if (obs() !== 69'h0) begin
      n_bad++;
      $display("FAIL %s idle_after got %h want 0", name, obs());
    end
    check_mem(name);
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.src_base = 32'd0;
    bus.dst_base = 32'd8;
    bus.len = 11'd4;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs() !== 69'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want 0", obs());
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== 69'h0) begin
      n_bad++;
      $display("FAIL reset_release got %h want 0", obs());
    end
  endtask

  task automatic test_basic();
    poke(16, 32'hAAAA_0001);
    poke(17, 32'hBBBB_0002);
    poke(18, 32'hCCCC_0003);
    poke(19, 32'hDDDD_0004);
    run_copy("basic", 32'd16, 32'd100, 4, 1'b0);
    n_cmp++;
    if (mem[103] !== 32'hDDDD_0004) begin
      n_bad++;
      $display("FAIL basic_last got %h want DDDD0004", mem[103]);
    end
  endtask

  task automatic test_zero_len();
    run_copy("zero_len", 32'd5, 32'd9, 0, 1'b0);
  endtask

  task automatic test_error();
    run_copy("err_src", 32'd1020, 32'd0, 5, 1'b0);
    run_copy("err_dst", 32'd0, 32'd1024, 1, 1'b0);
    run_copy("err_wrap", 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
    run_copy("edge_ok", 32'd1020, 32'd0, 4, 1'b0);
  endtask

  task automatic test_overlap();
    poke(0, 32'h1111_1111);
    poke(1, 32'h2222_2222);
    poke(2, 32'h3333_3333);
    run_copy("overlap", 32'd0, 32'd1, 2, 1'b0);
    n_cmp++;
    if (mem[2] !== 32'h1111_1111) begin
      n_bad++;
      $display("FAIL overlap_fwd got %h want 11111111", mem[2]);
    end
  endtask

  task automatic test_random();
    int len;
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 12);
      run_copy("random", 32'($urandom_range(0, MW - len)),
               32'($urandom_range(0, MW - len)), len, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    run_copy("b2b_a", 32'd200, 32'd300, 3, 1'b0);
    run_copy("b2b_b", 32'd300, 32'd400, 3, 1'b0);
    run_copy("b2b_c", 32'd10, 32'd20, 0, 1'b0);
    run_copy("b2b_d", 32'd900, 32'd1000, 2, 1'b0);
  endtask

  task automatic test_reset_abort();
    bus.src_base = 32'd500;
    bus.dst_base = 32'd600;
    bus.len = 11'd8;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ref_mem[600] = ref_mem[500];
    ref_mem[601] = ref_mem[501];
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== 69'h0) begin
      n_bad++;
      $display("FAIL abort_outputs got %h want 0", obs());
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== 69'h0) begin
        n_bad++;
        $display("FAIL abort_quiet got %h want 0", obs());
      end
    end
    check_mem("abort");
    run_copy("after_abort", 32'd500, 32'd700, 3, 1'b0);
  endtask

  task automatic test_reset_priority();
    bus.src_base = 32'd1;
    bus.dst_base = 32'd2;
    bus.len = 11'd3;
    bus.start = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== 69'h0) begin
      n_bad++;
      $display("FAIL rst_priority got %h want 0", obs());
    end
    check_mem("rst_priority");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.len = '0;
    init_mem();
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_overlap();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
